// File: rtl/fft_peak_tracker_if.sv
// Histogram write snoop (hwe/haddr/hdata) plus the peak and note results
// handed to game logic and the display.
interface fft_peak_tracker_if;
    logic        hwe;
    logic [9:0]  haddr;
    logic [15:0] hdata;
    logic        peak_valid;
    logic [9:0]  peak_bin;
    logic [15:0] peak_mag;
    logic        peak_present;
    logic        note_on;
    logic [9:0]  note_bin;
    logic        note_onset;
    logic        frame_error;
    logic [7:0]  frame_count;

    modport master (
        output hwe, haddr, hdata,
        input  peak_valid, peak_bin, peak_mag, peak_present,
        input  note_on, note_bin, note_onset, frame_error, frame_count
    );

    modport slave (
        input  hwe, haddr, hdata,
        output peak_valid, peak_bin, peak_mag, peak_present,
        output note_on, note_bin, note_onset, frame_error, frame_count
    );
endinterface

// File: rtl/fft_peak_tracker.sv
// Tracks the dominant bin of each complete FFT histogram frame and debounces
// successive frame peaks into a stable note indication.
module fft_peak_tracker #(
    parameter int unsigned MIN_BIN       = 4,
    parameter int unsigned MAX_BIN       = 511,
    parameter int unsigned LAST_BIN      = 1023,
    parameter logic [15:0] THRESHOLD     = 16'h0100,
    parameter int unsigned BIN_TOL       = 1,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                reset,
    fft_peak_tracker_if.slave   bus
);

    localparam logic [9:0] MIN_B    = 10'(MIN_BIN);
    localparam logic [9:0] MAX_B    = 10'(MAX_BIN);
    localparam logic [9:0] LAST_B   = 10'(LAST_BIN);
    localparam logic [9:0] TOL_B    = 10'(BIN_TOL);
    localparam logic [3:0] STABLE_C = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {S_SYNC, S_ACCUM, S_PUBLISH} state_t;

    state_t      r_state, w_next;
    logic        w_start, w_eval, w_err, w_publish;

    logic [9:0]  r_expected;
    logic [15:0] r_max;
    logic [9:0]  r_max_bin;

    logic        r_peak_valid, r_peak_present, r_note_on, r_note_onset, r_frame_error;
    logic [9:0]  r_peak_bin, r_note_bin, r_cand_bin;
    logic [15:0] r_peak_mag;
    logic [7:0]  r_frame_count;
    logic [3:0]  r_stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_next;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        w_next    = r_state;
        w_start   = 1'b0;
        w_eval    = 1'b0;
        w_err     = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (bus.hwe && bus.haddr == 10'd0) begin
                    w_start = 1'b1;
                    w_eval  = 1'b1;
                    w_next  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.hwe) begin
                    if (bus.haddr == r_expected) begin
                        w_eval = 1'b1;
                        if (bus.haddr == LAST_B) w_next = S_PUBLISH;
                    end else begin
                        w_err = 1'b1;
                        if (bus.haddr == 10'd0) begin
                            w_start = 1'b1;
                            w_eval  = 1'b1;
                        end else begin
                            w_next = S_SYNC;
                        end
                    end
                end
            end
            S_PUBLISH: begin
                w_publish = 1'b1;
                w_next    = S_SYNC;
                // Bin 0 of the next frame may arrive in the publish cycle itself.
                if (bus.hwe && bus.haddr == 10'd0) begin
                    w_start = 1'b1;
                    w_eval  = 1'b1;
                    w_next  = S_ACCUM;
                end
            end
            default: w_next = S_SYNC;
        endcase
    end

    logic [15:0] w_base_max;
    logic        w_take;

    assign w_base_max = w_start ? 16'd0 : r_max;
    assign w_take     = (bus.haddr >= MIN_B) && (bus.haddr <= MAX_B) && (bus.hdata > w_base_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_expected <= 10'd0;
            r_max      <= 16'd0;
            r_max_bin  <= 10'd0;
        end else if (w_eval) begin
            r_expected <= bus.haddr + 10'd1;
            if (w_take) begin
                r_max     <= bus.hdata;
                r_max_bin <= bus.haddr;
            end else if (w_start) begin
                r_max     <= 16'd0;
                r_max_bin <= 10'd0;
            end
        end
    end

    logic       w_present, w_same, w_qualify;
    logic [9:0] w_pub_bin, w_diff, w_new_cand;
    logic [3:0] w_new_cnt;

    always_comb begin
        w_present  = (r_max >= THRESHOLD);
        w_pub_bin  = w_present ? r_max_bin : 10'd0;
        w_diff     = (w_pub_bin >= r_cand_bin) ? (w_pub_bin - r_cand_bin) : (r_cand_bin - w_pub_bin);
        w_same     = (w_diff <= TOL_B) && (r_stable_cnt != 4'd0);
        w_new_cand = 10'd0;
        w_new_cnt  = 4'd0;
        if (w_present) begin
            if (w_same) begin
                w_new_cand = r_cand_bin;
                w_new_cnt  = (r_stable_cnt >= STABLE_C) ? STABLE_C : r_stable_cnt + 4'd1;
            end else begin
                w_new_cand = w_pub_bin;
                w_new_cnt  = 4'd1;
            end
        end
        w_qualify = w_present && (w_new_cnt == STABLE_C) &&
                    (!r_note_on || (w_new_cand != r_note_bin));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak_valid   <= 1'b0;
            r_peak_present <= 1'b0;
            r_peak_bin     <= 10'd0;
            r_peak_mag     <= 16'd0;
            r_frame_count  <= 8'd0;
            r_frame_error  <= 1'b0;
            r_cand_bin     <= 10'd0;
            r_stable_cnt   <= 4'd0;
            r_note_on      <= 1'b0;
            r_note_bin     <= 10'd0;
            r_note_onset   <= 1'b0;
        end else begin
            r_peak_valid <= w_publish;
            r_note_onset <= 1'b0;
            if (w_err) r_frame_error <= 1'b1;
            if (w_publish) begin
                r_peak_present <= w_present;
                r_peak_bin     <= w_pub_bin;
                r_peak_mag     <= r_max;
                r_frame_count  <= r_frame_count + 8'd1;
                r_frame_error  <= 1'b0;
                r_cand_bin     <= w_new_cand;
                r_stable_cnt   <= w_new_cnt;
                if (!w_present) begin
                    r_note_on <= 1'b0;
                end else if (w_qualify) begin
                    r_note_on    <= 1'b1;
                    r_note_bin   <= w_new_cand;
                    r_note_onset <= 1'b1;
                end
            end
        end
    end

    assign bus.peak_valid   = r_peak_valid;
    assign bus.peak_bin     = r_peak_bin;
    assign bus.peak_mag     = r_peak_mag;
    assign bus.peak_present = r_peak_present;
    assign bus.note_on      = r_note_on;
    assign bus.note_bin     = r_note_bin;
    assign bus.note_onset   = r_note_onset;
    assign bus.frame_error  = r_frame_error;
    assign bus.frame_count  = r_frame_count;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed bench for fft_peak_tracker: full histogram frames with hand-picked
// peaks, checked against hand-computed peak and note results.
module tb_fft_peak_tracker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_peak_tracker_if u_if ();

    fft_peak_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] mag [1024];

    // Snapshot of the outputs in each cycle that peak_valid is high.
    int          pv_count = 0;
    int          onset_count = 0;
    logic [9:0]  cap_bin;
    logic [15:0] cap_mag;
    logic        cap_present, cap_note_on, cap_onset, cap_ferr;
    logic [9:0]  cap_note_bin;
    logic [7:0]  cap_count;
    logic [9:0]  cap_bins [$];
    logic [15:0] cap_mags [$];

    always @(negedge clk) begin
        if (u_if.peak_valid === 1'b1) begin
            pv_count++;
            cap_bin      = u_if.peak_bin;
            cap_mag      = u_if.peak_mag;
            cap_present  = u_if.peak_present;
            cap_note_on  = u_if.note_on;
            cap_note_bin = u_if.note_bin;
            cap_onset    = u_if.note_onset;
            cap_ferr     = u_if.frame_error;
            cap_count    = u_if.frame_count;
            cap_bins.push_back(u_if.peak_bin);
            cap_mags.push_back(u_if.peak_mag);
        end
        if (u_if.note_onset === 1'b1) onset_count++;
    end

    task automatic write_bin(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        u_if.hwe   = 1'b1;
        u_if.haddr = a;
        u_if.hdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            u_if.hwe = 1'b0;
        end
    endtask

    task automatic clear_mag();
        for (int i = 0; i < 1024; i++) mag[i] = 16'h0000;
    endtask

    task automatic send_frame(input int first, input int last, input int skip, input bit trail_idle);
        for (int i = first; i <= last; i++)
            if (i != skip) write_bin(10'(i), mag[i]);
        if (trail_idle) idle(4);
    endtask

    task automatic frame_with_peak(input int b, input logic [15:0] m);
        clear_mag();
        mag[b] = m;
        send_frame(0, 1023, -1, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        u_if.hwe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({u_if.peak_valid, u_if.peak_bin, u_if.peak_mag, u_if.peak_present} !== 28'd0) begin
            n_bad++; $display("FAIL reset_peak: got %h expected 0",
                              {u_if.peak_valid, u_if.peak_bin, u_if.peak_mag, u_if.peak_present});
        end
        n_vec++;
        if ({u_if.note_on, u_if.note_bin, u_if.note_onset, u_if.frame_error, u_if.frame_count} !== 21'd0) begin
            n_bad++; $display("FAIL reset_note: got %h expected 0",
                              {u_if.note_on, u_if.note_bin, u_if.note_onset, u_if.frame_error, u_if.frame_count});
        end
        n_vec++;
    endtask

    task automatic test_basic();
        int pv0;
        pv0 = pv_count;
        clear_mag();
        mag[100] = 16'h0800;
        mag[200] = 16'h0400;
        send_frame(0, 1023, -1, 1'b0);
        idle(1);
        if (u_if.peak_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_early_valid: got %b expected 0", u_if.peak_valid);
        end
        n_vec++;
        idle(1);
        if (u_if.peak_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_valid: got %b expected 1", u_if.peak_valid);
        end
        n_vec++;
        idle(1);
        if (u_if.peak_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_valid_width: got %b expected 0", u_if.peak_valid);
        end
        n_vec++;
        idle(2);
        if (pv_count !== pv0 + 1) begin
            n_bad++; $display("FAIL basic_pulses: got %0d expected %0d", pv_count - pv0, 1);
        end
        n_vec++;
        if ({cap_bin, cap_mag, cap_present} !== {10'd100, 16'h0800, 1'b1}) begin
            n_bad++; $display("FAIL basic_peak: got bin=%0d mag=%h pres=%b expected bin=100 mag=0800 pres=1",
                              cap_bin, cap_mag, cap_present);
        end
        n_vec++;
        if ({cap_count, cap_note_on} !== {8'd1, 1'b0}) begin
            n_bad++; $display("FAIL basic_count_note: got cnt=%0d note_on=%b expected cnt=1 note_on=0",
                              cap_count, cap_note_on);
        end
        n_vec++;
    endtask

    task automatic test_note();
        int on0;
        do_reset();
        on0 = onset_count;
        for (int f = 1; f <= 3; f++) begin
            frame_with_peak(100, 16'h0900);
            if (onset_count - on0 !== ((f == 3) ? 1 : 0)) begin
                n_bad++; $display("FAIL note_onset_f%0d: got %0d expected %0d", f, onset_count - on0, (f == 3) ? 1 : 0);
            end
            n_vec++;
        end
        if ({cap_onset, cap_note_on, cap_note_bin} !== {1'b1, 1'b1, 10'd100}) begin
            n_bad++; $display("FAIL note_declared: got onset=%b on=%b bin=%0d expected onset=1 on=1 bin=100",
                              cap_onset, cap_note_on, cap_note_bin);
        end
        n_vec++;
        frame_with_peak(101, 16'h0900);
        if ({cap_bin, cap_note_on, cap_note_bin, cap_count} !== {10'd101, 1'b1, 10'd100, 8'd4}) begin
            n_bad++; $display("FAIL note_hold: got pbin=%0d on=%b nbin=%0d cnt=%0d expected pbin=101 on=1 nbin=100 cnt=4",
                              cap_bin, cap_note_on, cap_note_bin, cap_count);
        end
        n_vec++;
        if (onset_count - on0 !== 1) begin
            n_bad++; $display("FAIL note_no_reonset: got %0d expected 1", onset_count - on0);
        end
        n_vec++;
    endtask

    task automatic test_tie_range();
        clear_mag();
        mag[50]  = 16'h0500;
        mag[60]  = 16'h0500;
        mag[2]   = 16'hFFFF;
        mag[600] = 16'hFFFF;
        send_frame(0, 1023, -1, 1'b1);
        if ({cap_bin, cap_mag, cap_present} !== {10'd50, 16'h0500, 1'b1}) begin
            n_bad++; $display("FAIL tie_range: got bin=%0d mag=%h pres=%b expected bin=50 mag=0500 pres=1",
                              cap_bin, cap_mag, cap_present);
        end
        n_vec++;
        if ({cap_note_on, cap_note_bin, cap_onset} !== {1'b1, 10'd100, 1'b0}) begin
            n_bad++; $display("FAIL tie_note_kept: got on=%b bin=%0d onset=%b expected on=1 bin=100 onset=0",
                              cap_note_on, cap_note_bin, cap_onset);
        end
        n_vec++;
    endtask

    task automatic test_below_threshold();
        frame_with_peak(70, 16'h00FF);
        if ({cap_bin, cap_mag, cap_present} !== {10'd0, 16'h00FF, 1'b0}) begin
            n_bad++; $display("FAIL below_peak: got bin=%0d mag=%h pres=%b expected bin=0 mag=00ff pres=0",
                              cap_bin, cap_mag, cap_present);
        end
        n_vec++;
        if ({cap_note_on, cap_note_bin, cap_count} !== {1'b0, 10'd100, 8'd6}) begin
            n_bad++; $display("FAIL below_note_drop: got on=%b bin=%0d cnt=%0d expected on=0 bin=100 cnt=6",
                              cap_note_on, cap_note_bin, cap_count);
        end
        n_vec++;
    endtask

    task automatic test_error_and_back_to_back();
        int pv0;
        pv0 = pv_count;
        clear_mag();
        mag[100] = 16'h0800;
        send_frame(0, 1023, 300, 1'b1);
        if ({u_if.frame_error, u_if.frame_count} !== {1'b1, 8'd6} || pv_count !== pv0) begin
            n_bad++; $display("FAIL error_abort: got err=%b cnt=%0d pulses=%0d expected err=1 cnt=6 pulses=0",
                              u_if.frame_error, u_if.frame_count, pv_count - pv0);
        end
        n_vec++;
        send_frame(0, 1023, -1, 1'b1);
        if ({cap_ferr, cap_count, cap_bin} !== {1'b0, 8'd7, 10'd100} || pv_count !== pv0 + 1) begin
            n_bad++; $display("FAIL error_recover: got err=%b cnt=%0d bin=%0d pulses=%0d expected err=0 cnt=7 bin=100 pulses=1",
                              cap_ferr, cap_count, cap_bin, pv_count - pv0);
        end
        n_vec++;
        pv0 = pv_count;
        clear_mag();
        mag[300] = 16'h1234;
        send_frame(0, 1023, -1, 1'b0);
        clear_mag();
        mag[400] = 16'h2000;
        send_frame(0, 1023, -1, 1'b1);
        if (pv_count !== pv0 + 2) begin
            n_bad++; $display("FAIL b2b_pulses: got %0d expected 2", pv_count - pv0);
        end
        n_vec++;
        if ({cap_bins[$-1], cap_mags[$-1]} !== {10'd300, 16'h1234}) begin
            n_bad++; $display("FAIL b2b_first: got bin=%0d mag=%h expected bin=300 mag=1234",
                              cap_bins[$-1], cap_mags[$-1]);
        end
        n_vec++;
        if ({cap_bin, cap_mag, cap_count} !== {10'd400, 16'h2000, 8'd9}) begin
            n_bad++; $display("FAIL b2b_second: got bin=%0d mag=%h cnt=%0d expected bin=400 mag=2000 cnt=9",
                              cap_bin, cap_mag, cap_count);
        end
        n_vec++;
    endtask

    task automatic test_reset_mid_frame();
        int pv0;
        frame_with_peak(250, 16'h0700);
        clear_mag();
        mag[150] = 16'h0600;
        send_frame(0, 500, -1, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        u_if.haddr = 10'd501;
        repeat (2) @(negedge clk);
        if ({u_if.peak_valid, u_if.peak_bin, u_if.peak_mag, u_if.peak_present, u_if.note_on,
             u_if.note_bin, u_if.note_onset, u_if.frame_error, u_if.frame_count} !== 49'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got cnt=%0d bin=%0d mag=%h nbin=%0d expected all 0",
                              u_if.frame_count, u_if.peak_bin, u_if.peak_mag, u_if.note_bin);
        end
        n_vec++;
        reset = 1'b0;
        pv0 = pv_count;
        send_frame(501, 1023, -1, 1'b1);
        if (pv_count !== pv0 || u_if.frame_count !== 8'd0) begin
            n_bad++; $display("FAIL midreset_ignore: got pulses=%0d cnt=%0d expected 0 0",
                              pv_count - pv0, u_if.frame_count);
        end
        n_vec++;
        send_frame(0, 1023, -1, 1'b1);
        if ({cap_count, cap_bin, cap_mag} !== {8'd1, 10'd150, 16'h0600} || pv_count !== pv0 + 1) begin
            n_bad++; $display("FAIL midreset_next: got cnt=%0d bin=%0d mag=%h expected cnt=1 bin=150 mag=0600",
                              cap_count, cap_bin, cap_mag);
        end
        n_vec++;
    endtask

    initial begin
        u_if.hwe   = 1'b0;
        u_if.haddr = 10'd0;
        u_if.hdata = 16'd0;
        test_reset();
        test_basic();
        test_note();
        test_tie_range();
        test_below_threshold();
        test_error_and_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
